col_interp: RTL
===============

COL_INTERP -- requirements
Module: col_interp

Interface
REQ-001 The module SHALL have these parameters: LINE_W, default 1280, pixels per line; LINES_IN, default 720, input rows per frame; FRAC_W, default 4, weight fraction bits; STEP, default 8, vertical phase increment in Q(FRAC_W), with 8 giving 2x upscale.
REQ-002 The module SHALL have these ports, clock and reset first:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- in_data_en  in  1  line buffers are shifting in a new row this cycle
- buf1_data_in  in  8  newer-row pixel from the two-line buffer
- buf2_data_in  in  8  older-row pixel, same column
- o_row_req  out  1  upstream may start pushing the next row
- o_data  out  8  vertically interpolated pixel
- o_data_en  out  1  o_data valid
- o_frame_done  out  1  one-cycle pulse after the last output pixel of a frame
- o_err  out  1  sticky protocol-violation flag
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low, on ports clk and rst_n.

Function
REQ-004 The FSM SHALL have four states: FILL, PUSH, REPLAY, DONE.
- FILL: accept row 0, no output.
- PUSH: a new row streams in; interpolate.
- REPLAY: buffers recirculate with in_data_en=0; interpolate the same row pair again.
- DONE: single cycle, then FILL.
REQ-005 The column counter col_cnt (0..LINE_W-1) SHALL advance every FILL/PUSH cycle with in_data_en=1 and every REPLAY cycle, and SHALL wrap to 0 after LINE_W-1, marking the line end.
REQ-006 The row counter row_cnt SHALL increment at the end of every pushed row (FILL or PUSH).
REQ-007 The phase register ph, FRAC_W+1 bits, SHALL be 0 on the first output line of a frame and SHALL receive ph+STEP at every output-line end.
REQ-008 At each output-line end:
- if the new ph is at least 2^FRAC_W: subtract 2^FRAC_W and go to PUSH, or go to DONE when row_cnt==LINES_IN;
- otherwise go to REPLAY.
REQ-009 At the FILL line end, the state SHALL go to PUSH with ph=0.
REQ-010 o_row_req SHALL equal 1 in FILL and PUSH, and 0 in REPLAY and DONE.
REQ-011 o_row_req SHALL also be 0 during the final pixel cycle of a line whose successor is REPLAY; it is decoded combinationally from state, col_cnt and the next-phase decision.
REQ-012 Upstream SHALL start a row only while o_row_req=1, and a pushed row SHALL be LINE_W contiguous in_data_en cycles.
REQ-013 In PUSH and REPLAY, each counted cycle SHALL produce o_data = ((2^FRAC_W - w)*buf2_data_in + w*buf1_data_in + 2^(FRAC_W-1)) >> FRAC_W, where w = ph[FRAC_W-1:0].
REQ-014 The interpolation arithmetic SHALL use an 8+FRAC_W-bit unsigned intermediate with no saturation, since the result is always at most 255.
REQ-015 The datapath SHALL have a latency of 2 cycles (product register, then sum/round register); o_data_en SHALL be the counted-cycle flag delayed by 2.
REQ-016 o_frame_done SHALL pulse in the cycle o_data_en carries the last pixel of the final output line.
REQ-017 Protocol violations SHALL set o_err on the next edge and force the state to FILL with row_cnt=0 and ph=0. Violations are:
- in_data_en=1 in REPLAY;
- in_data_en=0 mid-row in FILL or PUSH, with col_cnt≠0.
REQ-018 In-flight pipeline data SHALL still drain after a violation.
REQ-019 o_err SHALL clear only on reset.

Reset
REQ-020 Reset SHALL force state=FILL, col_cnt=0, row_cnt=0 and ph=0.
REQ-021 Reset SHALL force o_data=0, o_data_en=0, o_frame_done=0, o_err=0 and the pipeline registers to 0.
REQ-022 o_row_req SHALL be 1 during reset.
REQ-023 Reset asserted mid-line SHALL abandon the frame immediately.

Structure
REQ-024 Shared package: the FSM state encoding, the pixel width constant 8, and the FRAC_W default.
REQ-025 One sub-module, interp_lerp, SHALL implement the 2-stage weighted-sum pipeline of REQ-013 and REQ-015; the FSM and counters SHALL reside in col_interp.

Verification
REQ-026 The bench SHALL use LINE_W=4, LINES_IN=3, STEP=8 unless stated otherwise, and SHALL cover these directed scenarios:
- Reset asserted -> o_data=0, o_data_en=0, o_err=0, o_row_req=1.
- Row0 all 10, row1 all 30 -> PUSH line gives four o_data=10 two cycles after each pixel; REPLAY line gives four 20; o_row_req=0 across the 4 replay cycles.
- buf2=0, buf1=255, w=15 -> o_data=239; buf2=255, buf1=0, w=8 -> o_data=128.
- STEP=16 -> no REPLAY ever, o_row_req held 1, 2 output lines per 3-row frame.
- in_data_en drops at col_cnt=2 of row1 -> o_err=1 next cycle, state FILL, o_row_req=1.
- Full 3-row frame -> exactly 4 output lines (16 pixels), o_frame_done one pulse aligned with pixel 16, next frame restarts at ph=0.

Source files
------------

// File: rtl/col_interp_pkg.sv
// Shared definitions for the vertical column interpolator: FSM encoding,
// pixel width and the default weight precision.
package col_interp_pkg;

    localparam int PIX_W      = 8;
    localparam int FRAC_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_PUSH   = 2'd1,
        ST_REPLAY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/col_interp_lerp.sv
// Two-stage weighted sum of two vertically adjacent pixels:
// stage 1 registers both weighted products, stage 2 adds, rounds and scales.
module interp_lerp
    import col_interp_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic [FRAC_W-1:0] w,
    input  logic [PIX_W-1:0]  old_pix,
    input  logic [PIX_W-1:0]  new_pix,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_en
);

    // The weighted sum never exceeds 255 * 2^FRAC_W, so this width is exact.
    localparam int SUM_W = PIX_W + FRAC_W;
    localparam int ONE   = 1 << FRAC_W;
    localparam int HALF  = 1 << (FRAC_W - 1);

    logic [FRAC_W:0]  w_old;
    logic [SUM_W-1:0] prod_old;
    logic [SUM_W-1:0] prod_new;
    logic [SUM_W-1:0] sum_rnd;
    logic             prod_en;

    assign w_old   = (FRAC_W + 1)'(ONE) - {1'b0, w};
    assign sum_rnd = prod_old + prod_new + SUM_W'(HALF);

    // Stage 1: register the two weighted products and their valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
        if (!rst_n) begin
            prod_en  <= 1'b0;
            prod_old <= '0;
            prod_new <= '0;
        end else begin
            prod_en  <= in_en;
            prod_old <= SUM_W'(w_old) * SUM_W'(old_pix);
            prod_new <= SUM_W'(w) * SUM_W'(new_pix);
        end
    end

    // Stage 2: add, round to nearest and drop the fraction bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en   <= 1'b0;
            out_data <= '0;
        end else begin
            out_en   <= prod_en;
            out_data <= PIX_W'(sum_rnd >> FRAC_W);
        end
    end

endmodule

// File: rtl/col_interp.sv
// Vertical upscaler control: sequences row pushes and replays of the
// two-line buffer, tracks the vertical phase and feeds interp_lerp.
module col_interp
    import col_interp_pkg::*;
#(
    parameter int LINE_W   = 1280,
    parameter int LINES_IN = 720,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int STEP     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_data_en,
    input  logic [PIX_W-1:0] buf1_data_in,
    input  logic [PIX_W-1:0] buf2_data_in,
    output logic             o_row_req,
    output logic [PIX_W-1:0] o_data,
    output logic             o_data_en,
    output logic             o_frame_done,
    output logic             o_err
);

    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int ROW_W = $clog2(LINES_IN + 1);
    localparam int PH_W  = FRAC_W + 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES_IN);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1 << FRAC_W);
    localparam logic [PH_W-1:0]  PH_STEP  = PH_W'(STEP);

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W-1:0] rows_seen;
    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  ph_sum;
    logic [PH_W-1:0]  ph_after;
    logic             is_in;
    logic             counted;
    logic             line_end;
    logic             ph_wrap;
    logic             last_line;
    logic             violation;
    logic             lerp_en;
    logic             last_pix;
    logic             done_d1;

    // A row is being received in FILL/PUSH; REPLAY advances on its own.
    assign is_in     = (state == ST_FILL) || (state == ST_PUSH);
    assign counted   = is_in ? in_data_en : (state == ST_REPLAY);
    assign line_end  = counted && (col_cnt == LAST_COL);
    assign violation = ((state == ST_REPLAY) && in_data_en) ||
                       (is_in && !in_data_en && (col_cnt != '0));

    // Next-phase decision: crossing one input-row pitch means a new row is needed.
    assign ph_sum    = ph + PH_STEP;
    assign ph_wrap   = (ph_sum >= PH_ONE);
    assign ph_after  = ph_wrap ? (ph_sum - PH_ONE) : ph_sum;

    // Rows consumed once the current line completes; a PUSH line adds its own row.
    assign rows_seen = (state == ST_PUSH) ? (row_cnt + ROW_W'(1)) : row_cnt;
    assign last_line = ph_wrap && (rows_seen == ROW_LAST);

    assign lerp_en   = counted && !violation && ((state == ST_PUSH) || (state == ST_REPLAY));
    assign last_pix  = lerp_en && line_end && last_line;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FILL;
        else        state <= state_nxt;
    end

    // Next-state decode; a protocol violation always restarts the frame.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (violation) begin
            state_nxt = ST_FILL;
        end else begin
            case (state)
                ST_FILL: if (line_end) state_nxt = ST_PUSH;
                ST_PUSH, ST_REPLAY: begin
                    if (line_end) begin
                        if (!ph_wrap)       state_nxt = ST_REPLAY;
                        else if (last_line) state_nxt = ST_DONE;
                        else                state_nxt = ST_PUSH;
                    end
                end
                ST_DONE: state_nxt = ST_FILL;
                default: state_nxt = ST_FILL;
            endcase
        end
    end

    // Row request: withheld while replaying, and on the last pixel before a replay.
    always_comb begin
        o_row_req = 1'b0;
        case (state)
            ST_FILL: o_row_req = 1'b1;
            ST_PUSH: o_row_req = !((col_cnt == LAST_COL) && !ph_wrap);
            default: o_row_req = 1'b0;
        endcase
    end

    // Column, row and phase counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            ph      <= '0;
        end else if (violation || (state == ST_DONE)) begin
            col_cnt <= '0;
            row_cnt <= '0;
            ph      <= '0;
        end else if (counted) begin
            col_cnt <= line_end ? '0 : (col_cnt + COL_W'(1));
            if (line_end) begin
                if (is_in) row_cnt <= row_cnt + ROW_W'(1);
                ph <= (state == ST_FILL) ? '0 : ph_after;
            end
        end
    end

    // Sticky error flag and frame-done pulse aligned with the datapath latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err        <= 1'b0;
            done_d1      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            if (violation) o_err <= 1'b1;
            done_d1      <= last_pix;
            o_frame_done <= done_d1;
        end
    end

    interp_lerp #(
        .FRAC_W (FRAC_W)
    ) u_lerp (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_en    (lerp_en),
        .w        (ph[FRAC_W-1:0]),
        .old_pix  (buf2_data_in),
        .new_pix  (buf1_data_in),
        .out_data (o_data),
        .out_en   (o_data_en)
    );

endmodule
